// File: rtl/param_register_bank.sv
// Parametrised control/status register bank: RW, RO (live input) and STICKY (clear-on-read) registers.
// Optional REGBANK_AUTOINC_EN: reg_num advances after each legal access for block transfers.
module param_register_bank #(
  parameter int                         NUM_REGS    = 32,
  parameter int                         DATA_W      = 32,
  parameter int                         ADDR_W      = 5,
  parameter logic [NUM_REGS*DATA_W-1:0] DEFAULTS    = '0,
  parameter logic [NUM_REGS-1:0]        RO_MASK     = '0,
  parameter logic [NUM_REGS-1:0]        STICKY_MASK = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  rx_data,
  input  logic                         reg_num_le,
  input  logic                         wr_en,
  input  logic                         rd_en,
  output logic [31:0]                  tx_data,
  output logic                         rd_valid,
  output logic                         illegal_reg_num,
  output logic                         wr_err,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  output logic [NUM_REGS-1:0]          wr_strobe,
  input  logic [NUM_REGS*DATA_W-1:0]   ro_in,
  input  logic [NUM_REGS*DATA_W-1:0]   sticky_set,
  input  logic                         err_clr
);

  logic [31:0]         reg_num_q, reg_num_d;
  logic [ADDR_W-1:0]   idx_w;
  logic [DATA_W-1:0]   value_w [NUM_REGS];
  logic [NUM_REGS-1:0] sel_w;
  logic [NUM_REGS-1:0] writable_w;
  logic [NUM_REGS-1:0] wr_strobe_q, wr_strobe_d;
  logic [31:0]         tx_data_q, tx_data_d;
  logic                rd_valid_q;
  logic                wr_err_q, wr_err_d;
  logic                unused_inputs;

  // Upper rx_data bits and slices belonging to other register classes are ignored.
  assign unused_inputs   = ^{rx_data, ro_in, sticky_set};

  assign illegal_reg_num = (reg_num_q >= 32'(NUM_REGS));
  assign idx_w           = reg_num_q[ADDR_W-1:0];

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      localparam bit is_sticky = STICKY_MASK[gi];
      localparam bit is_ro     = RO_MASK[gi] && !STICKY_MASK[gi];

      assign sel_w[gi]       = !illegal_reg_num && (idx_w == ADDR_W'(gi));
      assign writable_w[gi]  = !(is_sticky || is_ro);
      assign wr_strobe_d[gi] = wr_en && sel_w[gi] && writable_w[gi];
      assign reg_out[gi*DATA_W +: DATA_W] = value_w[gi];

      if (is_ro) begin : g_ro
        assign value_w[gi] = ro_in[gi*DATA_W +: DATA_W];
      end else begin : g_store
        logic [DATA_W-1:0] val_q, val_d;

        if (is_sticky) begin : g_sticky
          // An event arriving with the clearing read survives into the next value.
          assign val_d = (val_q & ~{DATA_W{rd_en && sel_w[gi]}})
                       | sticky_set[gi*DATA_W +: DATA_W];
        end else begin : g_rw
          assign val_d = wr_strobe_d[gi] ? rx_data[DATA_W-1:0] : val_q;
        end

        always_ff @(posedge clk) begin
          if (reset) begin
            val_q <= DEFAULTS[gi*DATA_W +: DATA_W];
          end else begin
            val_q <= val_d;
          end
        end

        assign value_w[gi] = val_q;
      end
    end
  endgenerate

  always_comb begin
    reg_num_d = reg_num_q;
`ifdef REGBANK_AUTOINC_EN
    if ((rd_en || wr_en) && !illegal_reg_num) begin
      reg_num_d = (reg_num_q == 32'(NUM_REGS - 1)) ? 32'd0 : reg_num_q + 32'd1;
    end
`endif
    if (reg_num_le) begin
      reg_num_d = rx_data;
    end

    tx_data_d = tx_data_q;
    if (rd_en) begin
      tx_data_d = illegal_reg_num ? 32'd0 : 32'(value_w[idx_w]);
    end

    // A new error outranks a simultaneous clear.
    wr_err_d = wr_err_q;
    if (wr_en && (illegal_reg_num || !writable_w[idx_w])) begin
      wr_err_d = 1'b1;
    end else if (err_clr) begin
      wr_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_num_q   <= '0;
      tx_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      wr_strobe_q <= '0;
      wr_err_q    <= 1'b0;
    end else begin
      reg_num_q   <= reg_num_d;
      tx_data_q   <= tx_data_d;
      rd_valid_q  <= rd_en;
      wr_strobe_q <= wr_strobe_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign rd_valid  = rd_valid_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_param_register_bank.sv
// Bench for param_register_bank: directed vector table, hand sequences, then randomized traffic vs a reference model.
module tb_param_register_bank;

  localparam int NR = 32;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam logic [NR-1:0] RO_M  = 32'h0210_0080;  // regs 7, 20, 25
  localparam logic [NR-1:0] STK_M = 32'h0200_1000;  // regs 12, 25 (sticky wins on 25)

  function automatic logic [NR*DW-1:0] mk_defaults();
    logic [NR*DW-1:0] d;
    for (int i = 0; i < NR; i++) begin
      if (i == 3)       d[i*DW +: DW] = 32'd100;
      else if (i == 12) d[i*DW +: DW] = 32'd0;
      else if (i == 25) d[i*DW +: DW] = 32'h80;
      else              d[i*DW +: DW] = 32'h1000 + 32'(i);
    end
    return d;
  endfunction

  localparam logic [NR*DW-1:0] DEFS = mk_defaults();

  logic             clk;
  logic             reset;
  logic [31:0]      rx_data;
  logic             reg_num_le;
  logic             wr_en;
  logic             rd_en;
  logic [31:0]      tx_data;
  logic             rd_valid;
  logic             illegal_reg_num;
  logic             wr_err;
  logic [NR*DW-1:0] reg_out;
  logic [NR-1:0]    wr_strobe;
  logic [NR*DW-1:0] ro_in;
  logic [NR*DW-1:0] sticky_set;
  logic             err_clr;

  param_register_bank #(
    .NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW),
    .DEFAULTS(DEFS), .RO_MASK(RO_M), .STICKY_MASK(STK_M)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .reg_num_le(reg_num_le),
    .wr_en(wr_en), .rd_en(rd_en), .tx_data(tx_data), .rd_valid(rd_valid),
    .illegal_reg_num(illegal_reg_num), .wr_err(wr_err), .reg_out(reg_out),
    .wr_strobe(wr_strobe), .ro_in(ro_in), .sticky_set(sticky_set), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    logic        rst, le, wr, rd, clr;
    logic [31:0] rx;
    logic [31:0] s12;
    logic        ev;
    logic [31:0] etx;
    logic        eerr;
    logic [31:0] estb;
    logic        eill;
    int          cidx;
    logic [31:0] cval;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic rst, le, wr, rd, clr, input logic [31:0] rx, s12,
                             input logic ev, input logic [31:0] etx, input logic eerr,
                             input logic [31:0] estb, input logic eill,
                             input int cidx, input logic [31:0] cval);
    vec_t r;
    r.rst = rst; r.le = le; r.wr = wr; r.rd = rd; r.clr = clr; r.rx = rx; r.s12 = s12;
    r.ev = ev; r.etx = etx; r.eerr = eerr; r.estb = estb; r.eill = eill;
    r.cidx = cidx; r.cval = cval;
    return r;
  endfunction

  task automatic acc(input logic le, wr, rd, clr, input logic [31:0] rx);
    reg_num_le = le; wr_en = wr; rd_en = rd; err_clr = clr; rx_data = rx;
    @(posedge clk); #1;
  endtask

  // Reference model state
  logic [31:0] m_val [NR];
  logic [31:0] m_num;
  logic        m_err;
  logic [31:0] m_tx;

  function automatic bit is_ro(input int j);
    return RO_M[j] && !STK_M[j];
  endfunction

  initial begin
    logic [31:0] ai_exp [4];
    reset = 1'b0; rx_data = '0; reg_num_le = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    sticky_set = '0;
    for (int i = 0; i < NR; i++) ro_in[i*DW +: DW] = 32'hCAFE0000 + 32'(i);

    //              rst le wr rd clr rx            s12  ev etx            err strobe   ill cidx cval
    tbl.push_back(v(1, 0, 0, 0, 0, 32'h0,        0,   0, 32'h0,        0,  32'h0,  0,  3,  32'd100));
    tbl.push_back(v(0, 1, 0, 0, 0, 32'd2,        0,   0, 32'h0,        0,  32'h0,  0,  25, 32'h80));
    tbl.push_back(v(0, 0, 1, 0, 0, 32'h11170,    0,   0, 32'h0,        0,  32'h4,  0,  2,  32'h11170));
    tbl.push_back(v(0, 1, 0, 0, 0, 32'd2,        0,   0, 32'h0,        0,  32'h0,  0,  -1, 32'h0));
    tbl.push_back(v(0, 1, 0, 1, 0, 32'd2,        0,   1, 32'h11170,    0,  32'h0,  0,  2,  32'h11170));
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,        0,   0, 32'h11170,    0,  32'h0,  0,  -1, 32'h0));
    tbl.push_back(v(0, 1, 0, 0, 0, 32'd7,        0,   0, 32'h11170,    0,  32'h0,  0,  -1, 32'h0));
    tbl.push_back(v(0, 0, 1, 0, 0, 32'h0,        0,   0, 32'h11170,    1,  32'h0,  0,  7,  32'hCAFE0007));
    tbl.push_back(v(0, 1, 0, 0, 0, 32'd7,        0,   0, 32'h11170,    1,  32'h0,  0,  -1, 32'h0));
    tbl.push_back(v(0, 1, 0, 1, 0, 32'd7,        0,   1, 32'hCAFE0007, 1,  32'h0,  0,  -1, 32'h0));
    tbl.push_back(v(0, 0, 0, 0, 1, 32'h0,        0,   0, 32'hCAFE0007, 0,  32'h0,  0,  -1, 32'h0));
    tbl.push_back(v(0, 1, 0, 0, 0, 32'd12,       0,   0, 32'hCAFE0007, 0,  32'h0,  0,  12, 32'h0));
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,        1,   0, 32'hCAFE0007, 0,  32'h0,  0,  12, 32'h1));
    tbl.push_back(v(0, 1, 0, 1, 0, 32'd12,       0,   1, 32'h1,        0,  32'h0,  0,  12, 32'h0));
    tbl.push_back(v(0, 1, 0, 1, 0, 32'd12,       2,   1, 32'h0,        0,  32'h0,  0,  12, 32'h2));
    tbl.push_back(v(0, 1, 0, 1, 0, 32'd12,       0,   1, 32'h2,        0,  32'h0,  0,  12, 32'h0));
    tbl.push_back(v(0, 1, 0, 0, 0, 32'h20,       0,   0, 32'h2,        0,  32'h0,  1,  -1, 32'h0));
    tbl.push_back(v(0, 0, 0, 1, 0, 32'h0,        0,   1, 32'h0,        0,  32'h0,  1,  -1, 32'h0));
    tbl.push_back(v(0, 0, 1, 0, 0, 32'hDEAD,     0,   0, 32'h0,        1,  32'h0,  1,  0,  32'h1000));
    tbl.push_back(v(0, 1, 0, 0, 1, 32'd3,        0,   0, 32'h0,        0,  32'h0,  0,  -1, 32'h0));
    tbl.push_back(v(0, 0, 1, 0, 0, 32'h55,       0,   0, 32'h0,        0,  32'h8,  0,  3,  32'h55));
    tbl.push_back(v(0, 1, 0, 0, 0, 32'd3,        0,   0, 32'h0,        0,  32'h0,  0,  -1, 32'h0));
    tbl.push_back(v(1, 1, 0, 1, 0, 32'd3,        0,   0, 32'h0,        0,  32'h0,  0,  3,  32'd100));
    tbl.push_back(v(0, 1, 0, 0, 0, 32'd3,        0,   0, 32'h0,        0,  32'h0,  0,  -1, 32'h0));
    tbl.push_back(v(0, 1, 0, 1, 0, 32'd3,        0,   1, 32'd100,      0,  32'h0,  0,  -1, 32'h0));
    tbl.push_back(v(0, 0, 1, 1, 0, 32'h77,       0,   1, 32'd100,      0,  32'h8,  0,  3,  32'h77));
    tbl.push_back(v(0, 1, 0, 0, 0, 32'd3,        0,   0, 32'd100,      0,  32'h0,  0,  -1, 32'h0));
    tbl.push_back(v(0, 1, 0, 1, 0, 32'd3,        0,   1, 32'h77,       0,  32'h0,  0,  -1, 32'h0));
    tbl.push_back(v(0, 1, 0, 1, 0, 32'd3,        0,   1, 32'h77,       0,  32'h0,  0,  -1, 32'h0));
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,        0,   0, 32'h77,       0,  32'h0,  0,  -1, 32'h0));
    tbl.push_back(v(0, 1, 0, 0, 0, 32'd7,        0,   0, 32'h77,       0,  32'h0,  0,  -1, 32'h0));
    tbl.push_back(v(0, 0, 1, 0, 1, 32'h0,        0,   0, 32'h77,       1,  32'h0,  0,  7,  32'hCAFE0007));
    tbl.push_back(v(0, 0, 0, 0, 1, 32'h0,        0,   0, 32'h77,       0,  32'h0,  0,  -1, 32'h0));

    for (int k = 0; k < tbl.size(); k++) begin
      reset = tbl[k].rst; reg_num_le = tbl[k].le; wr_en = tbl[k].wr; rd_en = tbl[k].rd;
      err_clr = tbl[k].clr; rx_data = tbl[k].rx;
      sticky_set = '0;
      sticky_set[12*DW +: DW] = tbl[k].s12;
      @(posedge clk); #1;
      $display("vec %0d: rd_valid=%0b tx=%h err=%0b strobe=%h ill=%0b",
               k, rd_valid, tx_data, wr_err, wr_strobe, illegal_reg_num);
      chk($sformatf("vec%0d rd_valid", k), 32'(rd_valid), 32'(tbl[k].ev));
      chk($sformatf("vec%0d tx_data", k), tx_data, tbl[k].etx);
      chk($sformatf("vec%0d wr_err", k), 32'(wr_err), 32'(tbl[k].eerr));
      chk($sformatf("vec%0d wr_strobe", k), wr_strobe, tbl[k].estb);
      chk($sformatf("vec%0d illegal", k), 32'(illegal_reg_num), 32'(tbl[k].eill));
      if (tbl[k].cidx >= 0)
        chk($sformatf("vec%0d reg_out[%0d]", k, tbl[k].cidx), reg_out[tbl[k].cidx*DW +: DW], tbl[k].cval);
    end
    reset = 1'b0; sticky_set = '0;

    // Block read starting at 30: the index either walks with wraparound or stays put.
    acc(1, 0, 0, 0, 32'd30);
`ifdef REGBANK_AUTOINC_EN
    ai_exp = '{32'h101E, 32'h101F, 32'h1000, 32'h1001};
`else
    ai_exp = '{32'h101E, 32'h101E, 32'h101E, 32'h101E};
`endif
    for (int i = 0; i < 4; i++) begin
      acc(0, 0, 1, 0, 32'h0);
      $display("blockrd %0d: rd_valid=%0b tx=%h", i, rd_valid, tx_data);
      chk($sformatf("blockrd%0d rd_valid", i), 32'(rd_valid), 32'h1);
      chk($sformatf("blockrd%0d tx_data", i), tx_data, ai_exp[i]);
    end
    acc(0, 0, 0, 0, 32'h0);
    chk("blockrd idle rd_valid", 32'(rd_valid), 32'h0);

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      logic             r_rst, r_le, r_wr, r_rd, r_clr, w_bad;
      logic [31:0]      r_rx, n_num, n_tx, e_stb;
      logic             n_err, e_valid, legal;
      logic [31:0]      n_val [NR];
      logic [NR*DW-1:0] e_out;
      int               idx, rj;

      r_rst = (c == 0) || ($urandom_range(0, 59) == 0);
      r_le  = ($urandom_range(0, 3) == 0);
      r_rx  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 35));
      r_wr  = ($urandom_range(0, 2) == 0);
      r_rd  = ($urandom_range(0, 1) == 0);
      r_clr = ($urandom_range(0, 5) == 0);
      for (int j = 0; j < NR; j++)
        sticky_set[j*DW +: DW] = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
      if ($urandom_range(0, 7) == 0) begin
        rj = $urandom_range(0, NR - 1);
        ro_in[rj*DW +: DW] = 32'($urandom);
      end
      reset = r_rst; reg_num_le = r_le; rx_data = r_rx; wr_en = r_wr; rd_en = r_rd; err_clr = r_clr;

      if (r_rst) begin
        for (int j = 0; j < NR; j++) n_val[j] = DEFS[j*DW +: DW];
        n_num = 0; n_err = 0; n_tx = 0; e_valid = 0; e_stb = 0;
      end else begin
        legal = (m_num < NR);
        idx   = int'(m_num[AW-1:0]);
        n_val = m_val;
        e_valid = r_rd;
        n_tx = m_tx;
        if (r_rd) n_tx = !legal ? 32'h0 : (is_ro(idx) ? ro_in[idx*DW +: DW] : m_val[idx]);
        e_stb = 0;
        w_bad = r_wr && (!legal || RO_M[idx] || STK_M[idx]);
        if (r_wr && !w_bad) begin
          n_val[idx] = r_rx;
          e_stb[idx] = 1'b1;
        end
        n_err = w_bad ? 1'b1 : (r_clr ? 1'b0 : m_err);
        for (int j = 0; j < NR; j++)
          if (STK_M[j])
            n_val[j] = ((r_rd && legal && idx == j) ? 32'h0 : m_val[j]) | sticky_set[j*DW +: DW];
        n_num = m_num;
`ifdef REGBANK_AUTOINC_EN
        if ((r_rd || r_wr) && legal) n_num = (m_num + 1) % NR;
`endif
        if (r_le) n_num = r_rx;
      end
      for (int j = 0; j < NR; j++) e_out[j*DW +: DW] = is_ro(j) ? ro_in[j*DW +: DW] : n_val[j];

      @(posedge clk); #1;
      $display("rand %0d: rst=%0b le=%0b wr=%0b rd=%0b rx=%h -> rd_valid=%0b tx=%h err=%0b",
               c, r_rst, r_le, r_wr, r_rd, r_rx, rd_valid, tx_data, wr_err);
      chk($sformatf("rand%0d rd_valid", c), 32'(rd_valid), 32'(e_valid));
      chk($sformatf("rand%0d tx_data", c), tx_data, n_tx);
      chk($sformatf("rand%0d wr_err", c), 32'(wr_err), 32'(n_err));
      chk($sformatf("rand%0d wr_strobe", c), wr_strobe, e_stb);
      chk($sformatf("rand%0d illegal", c), 32'(illegal_reg_num), 32'(n_num >= NR));
      checks++;
      if (reg_out === e_out) passes++;
      else begin
        for (int j = 0; j < NR; j++)
          if (reg_out[j*DW +: DW] !== e_out[j*DW +: DW]) begin
            $display("FAIL rand%0d reg_out[%0d]: got %h expected %h", c, j,
                     reg_out[j*DW +: DW], e_out[j*DW +: DW]);
            break;
          end
      end
      m_val = n_val; m_num = n_num; m_err = n_err; m_tx = n_tx;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/param_register_bank.md
Name: param_register_bank

Overview:
- Parametrised successor to the fixed 32x32 control/status register block. Sits between the Master FPGA register link and the acquisition, DDR3 and slow-control logic.
- Provides NUM_REGS registers of DATA_W bits each. Each register is classed by parameter mask as RW, RO (live input) or STICKY (event-latched, clear-on-read), with a per-register default value.
- Adds to the previous generation: a registered read-valid handshake, per-register write strobes, sticky status capture, a write-error flag, and full synchronous reset to defaults.

Parameters:
- NUM_REGS, 32: number of registers (2..256).
- DATA_W, 32: register width (8..32).
- ADDR_W, 5: index bits used; must satisfy 2**ADDR_W >= NUM_REGS.
- DEFAULTS, all 0: NUM_REGS*DATA_W flattened reset values; register i occupies bits [i*DATA_W +: DATA_W].
- RO_MASK, 0: bit i=1 makes register i read-only, reading ro_in slice i.
- STICKY_MASK, 0: bit i=1 makes register i sticky. Takes precedence over RO_MASK.

Ports:
- clk, input, 1: 125 MHz interconnect clock.
- reset, input, 1: synchronous, active-high.
- rx_data, input, 32: register number or write data from the Master FPGA.
- reg_num_le, input, 1: load reg_num from rx_data.
- wr_en, input, 1: write rx_data[DATA_W-1:0] to the selected register.
- rd_en, input, 1: read the selected register.
- tx_data, output, 32: read data, zero-extended.
- rd_valid, output, 1: one-cycle pulse when tx_data is updated.
- illegal_reg_num, output, 1: reg_num >= NUM_REGS.
- wr_err, output, 1: sticky error flag.
- reg_out, output, NUM_REGS*DATA_W: current register contents.
- wr_strobe, output, NUM_REGS: one-cycle pulse per accepted write.
- ro_in, input, NUM_REGS*DATA_W: live values for RO registers.
- sticky_set, input, NUM_REGS*DATA_W: per-bit event inputs for STICKY registers.
- err_clr, input, 1: clears wr_err.

Behaviour:
- Reset: reg_num=0; every RW and STICKY register = DEFAULTS slice; tx_data=0; rd_valid=0; wr_strobe=0; wr_err=0. Reset dominates every other input, including mid-access.
- reg_num: 32-bit, loaded from rx_data on reg_num_le. illegal_reg_num is combinational from reg_num.
- Access uses the reg_num value held before the current edge. With reg_num_le together with rd_en or wr_en in the same cycle, the access uses the old index and the new index loads at the same edge.
- Write (wr_en, legal index, RW register):
  - Register updates at the next edge.
  - wr_strobe[i] is high for exactly that one cycle. reg_out reflects the new value from the following cycle.
- Write to an RO or STICKY register, or with an illegal index:
  - No register changes and no strobe.
  - wr_err is set the next cycle and stays set until err_clr or reset. If err_clr and a new error occur in the same cycle, the set wins.
- Read (rd_en): tx_data and rd_valid register at the next edge, giving 1-cycle latency. rd_valid is high for one cycle.
  - Source is the register value, ro_in slice, or sticky value, sampled before the edge.
  - Illegal index returns 0, still pulses rd_valid, and does not set wr_err.
  - tx_data holds its value between reads.
- rd_en and wr_en together on the same register: the read returns the pre-write value, and the write takes effect.
- STICKY register i, each cycle: value <= (value & ~clear_mask) | sticky_set slice.
  - clear_mask is all-ones on the cycle a read of register i is issued, and 0 otherwise.
  - If an event arrives on the same cycle as the clearing read, the event bit survives: it is set after the read and not reported in that read.
- Back-to-back rd_en every cycle is supported: one rd_valid per rd_en, each with 1-cycle latency.
- DATA_W < 32: rx_data upper bits are ignored on write; tx_data upper bits read as 0.

Optional Feature:
- Macro REGBANK_AUTOINC_EN.
- Defined: after each accepted rd_en or wr_en with a legal index and without reg_num_le in that cycle, reg_num increments by 1. It wraps from NUM_REGS-1 to 0. This permits block read/write without re-addressing.
- Illegal-index accesses do not increment.
- Not defined: reg_num changes only on reg_num_le or reset.

Test Plan:
- Write then read:
  - Stimulus: reset; reg_num_le with rx_data=2; wr_en with rx_data=0x0001_1170; rd_en.
  - Required: wr_strobe[2] pulses once; reg_out slice 2 = 0x11170; rd_valid one cycle after rd_en with tx_data=0x0001_1170.
- RO protection:
  - Stimulus: RO_MASK bit 7 set, ro_in slice 7=0xCAFE0007; wr_en 0x0 to reg 7; then rd_en.
  - Required: wr_err=1, no wr_strobe, tx_data=0xCAFE0007; err_clr returns wr_err to 0.
- Sticky clear-on-read:
  - Stimulus: STICKY_MASK bit 12; sticky_set slice 12=0x1 pulsed; rd_en; then sticky_set=0x2 issued in the same cycle as a second rd_en.
  - Required: first read returns 0x1; second read returns 0x0; a third read returns 0x2.
- Illegal index:
  - Stimulus: reg_num_le with rx_data=0x20, NUM_REGS=32; rd_en; wr_en.
  - Required: illegal_reg_num=1; tx_data=0 with rd_valid pulse; wr_err=1; no register changes.
- Reset mid-operation:
  - Stimulus: write 0x55 to reg 3 (DEFAULTS slice 3=100), then reset asserted in the same cycle as rd_en.
  - Required: no rd_valid; reg 3 = 100; a following read of reg 3 returns 100.
- Auto-increment (REGBANK_AUTOINC_EN defined):
  - Stimulus: reg_num_le=30; three rd_en cycles.
  - Required: reads return regs 30, 31, 0 in order; reg_num ends at 1.
